p4_router_ingress_rr_merge: RTL
===============================

P4_ROUTER_INGRESS_RR_MERGE -- requirements
Module: p4_router_ingress_rr_merge

Interface
- REQ-001 SHALL have parameter NUM_PORTS, default 4: number of ingress ports, >=2.
- REQ-002 SHALL have parameter DATA_BYTES, default 8: tdata width in bytes, shared by all ports and the output.
- REQ-003 SHALL have parameter MTU_BYTES, default 1500: maximum frame length. MTU_WORDS = ceil(MTU_BYTES/DATA_BYTES).
- REQ-004 SHALL have parameter COUNTER_WIDTH, default 32: width of each statistics counter.
- REQ-005 SHALL use one clock and an asynchronous active-low reset.
- REQ-006 clk  in  1  sole clock.
- REQ-007 aresetn  in  1  asynchronous active-low reset.
- REQ-008 s_tvalid, s_tready, s_tlast  in/out/in  NUM_PORTS  per-port AXIS handshake and last.
- REQ-009 s_tdata  in  NUM_PORTS*DATA_BYTES*8  per-port data; port p occupies slice p.
- REQ-010 s_tkeep  in  NUM_PORTS*DATA_BYTES  per-port keep.
- REQ-011 m_tvalid, m_tready, m_tlast  out/in/out  1  merged output handshake and last.
- REQ-012 m_tdata, m_tkeep  out  DATA_BYTES*8, DATA_BYTES  merged data and keep.
- REQ-013 m_tid  out  max(1,$clog2(NUM_PORTS))  source port of the current beat.
- REQ-014 m_tuser  out  1  error flag, valid on the last beat only: 1 = truncated frame.
- REQ-015 port_enable  in  NUM_PORTS  per-port enable.
- REQ-016 cnt_clear  in  NUM_PORTS  one-cycle clear strobe for that port's counters.
- REQ-017 frame_cnt, oversize_cnt, drop_cnt  out  NUM_PORTS*COUNTER_WIDTH each  per-port counters.
- REQ-018 port_active  out  NUM_PORTS  1 while the port is granted or discarding.

Function
- REQ-019 The output SHALL be one register stage that loads when !m_tvalid || m_tready; latency from s handshake to m_tvalid SHALL be 1 cycle.
- REQ-020 The arbiter FSM SHALL have two states:
  - IDLE: select the lowest-index eligible port at or after (last_grant+1) mod NUM_PORTS, wrapping; eligible = s_tvalid & port_enable & !discarding. Go to GRANT(p) on the next cycle.
  - GRANT(p): go to IDLE after the accepted beat with output tlast.
- REQ-021 In GRANT(p), s_tready[p] SHALL equal (!m_tvalid || m_tready). Other enabled, non-discarding ports SHALL hold s_tready=0.
- REQ-022 A grant SHALL cover a whole frame, and round-robin order SHALL advance per frame. Arbitration overhead SHALL be 1 idle cycle per frame.
- REQ-023 A per-grant word counter SHALL count accepted beats, with width $clog2(MTU_WORDS+1).
- REQ-024 If beat MTU_WORDS is accepted with s_tlast=0, the output SHALL carry m_tlast=1 and m_tuser=1, oversize_cnt[p] SHALL increment, and port p SHALL enter discard.
- REQ-025 A frame of exactly MTU_WORDS beats ending in tlast SHALL be passed intact with m_tuser=0.
- REQ-026 In discard, the port SHALL hold s_tready=1 and drop all beats through tlast, inclusive, then clear discard. Other ports SHALL remain arbitrable meanwhile.
- REQ-027 An ungranted port with port_enable=0 SHALL hold s_tready=1 and drop its beats. drop_cnt[p] SHALL increment per dropped tlast.
- REQ-028 Deasserting port_enable during GRANT(p) SHALL NOT cut the frame; it SHALL complete normally.
- REQ-029 frame_cnt[p] SHALL increment when an output tlast from port p loads into the output register, truncated frames included.
- REQ-030 All counters SHALL saturate at all-ones. cnt_clear SHALL win over a simultaneous increment, and the counter SHALL read 0 next cycle.
- REQ-031 Data, keep and tid SHALL be passed unmodified. m_tuser SHALL be 0 on non-last beats.

Reset
- REQ-032 On aresetn low, outputs SHALL clear asynchronously: m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, m_tkeep=0, m_tid=0, s_tready=0, port_active=0, all counters 0.
- REQ-033 On aresetn low, state SHALL clear: FSM=IDLE, discard flags cleared, last_grant=NUM_PORTS-1 so port 0 wins first.
- REQ-034 Reset mid-frame SHALL abandon the frame; no partial state SHALL survive deassertion.

Verification (NUM_PORTS=4, DATA_BYTES=8, MTU_BYTES=64 -> MTU_WORDS=8)
- REQ-035 Ports 0 and 2 offer 3-beat frames together -> port 0 frame (m_tid=0), 1 idle cycle, then port 2 frame (m_tid=2); frame_cnt[0]=frame_cnt[2]=1.
- REQ-036 Port 1 sends 10 beats -> 8 beats out, beat 8 has m_tlast=1 and m_tuser=1; beats 9-10 consumed and not output; oversize_cnt[1]=1, frame_cnt[1]=1. A following 8-beat frame -> m_tuser=0, oversize_cnt[1] stays 1.
- REQ-037 m_tready held low 5 cycles mid-frame -> m_tdata stable, s_tready[p]=0, no beat lost or duplicated.
- REQ-038 port_enable[3]=0 with two frames offered -> s_tready[3]=1, nothing output, drop_cnt[3]=2. Disabling a granted port mid-frame -> frame completes.
- REQ-039 aresetn pulsed low mid-frame -> outputs 0 immediately; after release, new frames start from port 0; cnt_clear coincident with an increment -> counter reads 0.

Source files
------------

// File: rtl/p4_router_ingress_rr_merge.sv
// Round-robin ingress merger for the P4 router front end.
// NUM_PORTS AXI-Stream slave ports are merged into one master stream through
// a single output register stage. A grant covers a whole frame. Frames longer
// than MTU_WORDS beats are cut at beat MTU_WORDS and flagged with m_tuser=1 on
// that last beat, and the port then swallows the rest of the frame.
// Ports:
//   clk, aresetn                          clock, async active-low reset
//   s_tvalid/s_tready/s_tlast [NP]        per-port handshake + last
//   s_tdata [NP*DW], s_tkeep [NP*DB]      per-port payload, port p in slice p
//   m_tvalid/m_tready/m_tlast/m_tuser     merged handshake, last, truncation flag
//   m_tdata, m_tkeep, m_tid               merged payload and source port
//   port_enable, cnt_clear [NP]           per-port enable / counter clear strobe
//   frame_cnt/oversize_cnt/drop_cnt       per-port saturating statistics
//   port_active [NP]                      port granted or discarding

// Per-port statistics: three saturating counters, clear wins over increment.
module p4_rim_port_stats #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          clr,
  input  logic          inc_frame,
  input  logic          inc_over,
  input  logic          inc_drop,
  output logic [CW-1:0] frame_cnt,
  output logic [CW-1:0] oversize_cnt,
  output logic [CW-1:0] drop_cnt
);
  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c, input logic inc);
    return (inc && (c != {CW{1'b1}})) ? c + CW'(1) : c;
  endfunction

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt    <= '0;
      oversize_cnt <= '0;
      drop_cnt     <= '0;
    end else if (clr) begin
      frame_cnt    <= '0;
      oversize_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      frame_cnt    <= bump(frame_cnt, inc_frame);
      oversize_cnt <= bump(oversize_cnt, inc_over);
      drop_cnt     <= bump(drop_cnt, inc_drop);
    end
  end
endmodule

module p4_router_ingress_rr_merge #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_BYTES    = 8,
  parameter int MTU_BYTES     = 1500,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  output logic [NUM_PORTS-1:0]                 s_tready,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]    s_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]      s_tkeep,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic [DATA_BYTES*8-1:0]              m_tdata,
  output logic [DATA_BYTES-1:0]                m_tkeep,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] m_tid,
  output logic                                 m_tuser,
  input  logic [NUM_PORTS-1:0]                 port_enable,
  input  logic [NUM_PORTS-1:0]                 cnt_clear,
  output logic [NUM_PORTS*COUNTER_WIDTH-1:0]   frame_cnt,
  output logic [NUM_PORTS*COUNTER_WIDTH-1:0]   oversize_cnt,
  output logic [NUM_PORTS*COUNTER_WIDTH-1:0]   drop_cnt,
  output logic [NUM_PORTS-1:0]                 port_active
);
  localparam int DW        = DATA_BYTES * 8;
  localparam int MTU_WORDS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int WCW       = $clog2(MTU_WORDS + 1);
  localparam int TIDW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(MTU_WORDS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nx;
  logic [TIDW-1:0]      gnt, last_grant, pick, hi, lo;
  logic                 pick_vld, hi_vld;
  logic [NUM_PORTS-1:0] discard, elig, grant_vec;
  logic [NUM_PORTS-1:0] inc_frame, inc_over, inc_drop;
  logic [WCW-1:0]       wcnt;
  logic                 run, out_ld, acc, trunc, out_last;
  logic                 sel_last;
  logic [DW-1:0]        sel_data;
  logic [DATA_BYTES-1:0] sel_keep;

  // run keeps every s_tready low while reset is held and for the first cycle
  // after release, so disabled ports do not report ready during reset.
  assign out_ld   = !m_tvalid || m_tready;
  assign elig     = s_tvalid & port_enable & ~discard;
  assign sel_last = s_tlast[gnt];
  assign sel_data = s_tdata[int'(gnt)*DW +: DW];
  assign sel_keep = s_tkeep[int'(gnt)*DATA_BYTES +: DATA_BYTES];
  assign acc      = (state == GRANT) && s_tvalid[gnt] && s_tready[gnt];
  // Beat MTU_WORDS without tlast: force a last beat and mark it truncated.
  assign trunc    = acc && (wcnt == LAST_W) && !sel_last;
  assign out_last = sel_last || trunc;
  assign port_active = grant_vec | discard;

  always_comb begin
    s_tready  = '0;
    grant_vec = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      grant_vec[p] = (state == GRANT) && (gnt == TIDW'(p));
      if (!run)                             s_tready[p] = 1'b0;
      else if (grant_vec[p])                s_tready[p] = out_ld;
      else if (discard[p] || !port_enable[p]) s_tready[p] = 1'b1;
    end
  end

  // Round robin: first eligible port above last_grant, else lowest eligible.
  always_comb begin
    hi = '0; lo = '0; hi_vld = 1'b0; pick_vld = 1'b0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (elig[p]) begin
        lo = TIDW'(p);
        pick_vld = 1'b1;
        if (TIDW'(p) > last_grant) begin
          hi = TIDW'(p);
          hi_vld = 1'b1;
        end
      end
    end
    pick = hi_vld ? hi : lo;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = GRANT;
      GRANT:   if (acc && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      run        <= 1'b0;
      gnt        <= '0;
      last_grant <= TIDW'(NUM_PORTS - 1);
      wcnt       <= '0;
      discard    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tid      <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (state == IDLE && pick_vld) begin
        gnt        <= pick;
        last_grant <= pick;
        wcnt       <= '0;
      end
      if (acc) wcnt <= out_last ? '0 : wcnt + WCW'(1);
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (trunc && gnt == TIDW'(p))
          discard[p] <= 1'b1;
        else if (discard[p] && s_tvalid[p] && s_tlast[p])
          discard[p] <= 1'b0;
      end
      if (out_ld) begin
        m_tvalid <= acc;
        if (acc) begin
          m_tdata <= sel_data;
          m_tkeep <= sel_keep;
          m_tid   <= gnt;
          m_tlast <= out_last;
          m_tuser <= trunc;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign inc_frame[p] = acc && out_last && (gnt == TIDW'(p));
    assign inc_over[p]  = trunc && (gnt == TIDW'(p));
    // Only beats dropped because the port is disabled count; discard of a
    // truncated frame's tail is already accounted for in oversize_cnt.
    assign inc_drop[p]  = s_tvalid[p] && s_tready[p] && s_tlast[p] &&
                          !grant_vec[p] && !discard[p] && !port_enable[p];

    p4_rim_port_stats #(.CW(COUNTER_WIDTH)) u_stats (
      .clk          (clk),
      .aresetn      (aresetn),
      .clr          (cnt_clear[p]),
      .inc_frame    (inc_frame[p]),
      .inc_over     (inc_over[p]),
      .inc_drop     (inc_drop[p]),
      .frame_cnt    (frame_cnt[p*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .oversize_cnt (oversize_cnt[p*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .drop_cnt     (drop_cnt[p*COUNTER_WIDTH +: COUNTER_WIDTH])
    );
  end
endmodule
